// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared widths, constants and defaults for the regfile write-port arbiter.
package regfile_wport_arbiter_pkg;

  localparam int unsigned RegAddrBus  = 5;
  localparam int unsigned RegBus      = 32;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

  localparam int unsigned LuFifoDepth = 2;
  localparam int unsigned LuMaxWait   = 4;

  typedef struct packed {
    logic [RegAddrBus-1:0] addr;
    logic [RegBus-1:0]     data;
  } wr_entry_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Small FIFO buffering long-latency-unit writeback entries (address + data).
module rf_wr_fifo
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = LuFifoDepth
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wr_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wr_entry_t head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  wr_entry_t       mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            push_ok, pop_ok;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the regfile write port between MEM/WB and a buffered long-latency unit,
// tracking outstanding LU destinations and requesting bubbles when the buffer starves.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = LuFifoDepth,
  parameter int unsigned MAX_WAIT = LuMaxWait
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [RegAddrBus-1:0] wb_waddr,
  input  logic [RegBus-1:0]     wb_wdata,
  input  logic                  iss_valid,
  input  logic [RegAddrBus-1:0] iss_waddr,
  input  logic                  lu_valid,
  input  logic [RegAddrBus-1:0] lu_waddr,
  input  logic [RegBus-1:0]     lu_wdata,
  output logic                  lu_ready,
  input  logic [RegAddrBus-1:0] raddr1,
  input  logic [RegAddrBus-1:0] raddr2,
  output logic                  rd_busy1,
  output logic                  rd_busy2,
  output logic                  we,
  output logic [RegAddrBus-1:0] waddr,
  output logic [RegBus-1:0]     wdata,
  output logic                  stallreq,
  output logic                  err
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  logic             fifo_full, fifo_empty;
  wr_entry_t        fifo_head, push_entry;
  logic             wb_own, drain, push, drop;
  logic             iss_set, iss_err, push_err;
  logic [31:0]      busy_q, busy_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             stallreq_q, stallreq_d;
  logic             err_q, err_d;

  assign wb_own     = wb_we && (wb_waddr != '0);
  assign drain      = !wb_own && !fifo_empty;
  assign push       = lu_valid && !fifo_full;
  assign drop       = lu_valid && fifo_full;
  assign push_entry = '{addr: lu_waddr, data: lu_wdata};

  rf_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (drain),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  assign iss_set  = iss_valid && (iss_waddr != '0);
  assign iss_err  = iss_set && busy_q[iss_waddr];
  assign push_err = push && !busy_q[lu_waddr];

  // Issue is applied after the drain clear so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (drain)   busy_d[fifo_head.addr] = 1'b0;
    if (iss_set) busy_d[iss_waddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (fifo_empty || drain)     wait_cnt_d = '0;
    else if (wait_cnt_q < WaitMax) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  assign stallreq_d = (wait_cnt_q == WaitMax) && !drain;
  assign err_d      = err_q || drop || iss_err || push_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      wait_cnt_q <= '0;
      stallreq_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      wait_cnt_q <= wait_cnt_d;
      stallreq_q <= stallreq_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = ZeroWord;
    if (rst) begin
      if (wb_own) begin
        we    = WriteEnable;
        waddr = wb_waddr;
        wdata = wb_wdata;
      end else if (!fifo_empty) begin
        we    = WriteEnable;
        waddr = fifo_head.addr;
        wdata = fifo_head.data;
      end
    end
  end

  assign lu_ready = rst && !fifo_full;
  assign rd_busy1 = rst && busy_q[raddr1] && (raddr1 != '0);
  assign rd_busy2 = rst && busy_q[raddr2] && (raddr2 != '0);
  assign stallreq = rst && stallreq_q;
  assign err      = rst && err_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench: per-cycle vector table plus hand sequences for reset and starvation.
module tb_regfile_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        iss_valid;
  logic [4:0]  iss_waddr;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic [4:0]  raddr1, raddr2;
  logic        rd_busy1, rd_busy2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stallreq;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(
    .DEPTH    (2),
    .MAX_WAIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .iss_valid (iss_valid),
    .iss_waddr (iss_waddr),
    .lu_valid  (lu_valid),
    .lu_waddr  (lu_waddr),
    .lu_wdata  (lu_wdata),
    .lu_ready  (lu_ready),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rd_busy1  (rd_busy1),
    .rd_busy2  (rd_busy2),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .stallreq  (stallreq),
    .err       (err)
  );

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        e_ready;
    logic        e_busy1;
    logic        e_busy2;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic        e_err;
  } vec_t;

  localparam int NumVec = 25;
  vec_t vecs [NumVec];

  function automatic vec_t mk(logic wwe, logic [4:0] wa, logic [31:0] wd, logic iv,
                              logic [4:0] ia, logic lv, logic [4:0] la, logic [31:0] ld,
                              logic [4:0] r1, logic [4:0] r2, logic ery, logic eb1,
                              logic eb2, logic ewe, logic [4:0] ewa, logic [31:0] ewd,
                              logic est, logic eer);
    vec_t v;
    v.wb_we = wwe; v.wb_waddr = wa; v.wb_wdata = wd;
    v.iss_valid = iv; v.iss_waddr = ia;
    v.lu_valid = lv; v.lu_waddr = la; v.lu_wdata = ld;
    v.raddr1 = r1; v.raddr2 = r2;
    v.e_ready = ery; v.e_busy1 = eb1; v.e_busy2 = eb2;
    v.e_we = ewe; v.e_waddr = ewa; v.e_wdata = ewd;
    v.e_stall = est; v.e_err = eer;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    iss_valid = 0; iss_waddr = 0;
    lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
    raddr1 = 0; raddr2 = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " we"}, 32'(we), 0);
    chk({tag, " waddr"}, 32'(waddr), 0);
    chk({tag, " wdata"}, wdata, 0);
    chk({tag, " lu_ready"}, 32'(lu_ready), 0);
    chk({tag, " rd_busy1"}, 32'(rd_busy1), 0);
    chk({tag, " rd_busy2"}, 32'(rd_busy2), 0);
    chk({tag, " stallreq"}, 32'(stallreq), 0);
    chk({tag, " err"}, 32'(err), 0);
  endtask

  initial begin
    int rise;

    //             wwe wa  wd       iv ia lv la  ld        r1 r2  rdy b1 b2 we wa  wd       st er
    // Single LU result drains one cycle after the push.
    vecs[0]  = mk(0, 0, 0,        0, 0, 0, 0,  0,        0, 0,  1, 0, 0, 0, 0, 0,        0, 0);
    vecs[1]  = mk(0, 0, 0,        1, 7, 0, 0,  0,        7, 0,  1, 0, 0, 0, 0, 0,        0, 0);
    vecs[2]  = mk(0, 0, 0,        0, 0, 1, 7,  32'h1234, 7, 0,  1, 1, 0, 0, 0, 0,        0, 0);
    vecs[3]  = mk(0, 0, 0,        0, 0, 0, 0,  0,        7, 0,  1, 1, 0, 1, 7, 32'h1234, 0, 0);
    vecs[4]  = mk(0, 0, 0,        0, 0, 0, 0,  0,        7, 0,  1, 0, 0, 0, 0, 0,        0, 0);
    // MEM/WB keeps the port for three cycles; r5 waits.
    vecs[5]  = mk(0, 0, 0,        1, 5, 0, 0,  0,        5, 0,  1, 0, 0, 0, 0, 0,        0, 0);
    vecs[6]  = mk(1, 3, 32'h55,   0, 0, 1, 5,  32'hAA,   5, 0,  1, 1, 0, 1, 3, 32'h55,   0, 0);
    vecs[7]  = mk(1, 3, 32'h55,   0, 0, 0, 0,  0,        5, 0,  1, 1, 0, 1, 3, 32'h55,   0, 0);
    vecs[8]  = mk(1, 3, 32'h55,   0, 0, 0, 0,  0,        5, 0,  1, 1, 0, 1, 3, 32'h55,   0, 0);
    vecs[9]  = mk(0, 0, 0,        0, 0, 0, 0,  0,        5, 0,  1, 1, 0, 1, 5, 32'hAA,   0, 0);
    vecs[10] = mk(0, 0, 0,        0, 0, 0, 0,  0,        5, 0,  1, 0, 0, 0, 0, 0,        0, 0);
    // A write to r0 does not claim the port.
    vecs[11] = mk(1, 0, 32'hDEAD, 0, 0, 0, 0,  0,        0, 0,  1, 0, 0, 0, 0, 0,        0, 0);
    // Fill the FIFO under continuous wb writes, then drain in order.
    vecs[12] = mk(0, 0, 0,        1, 8, 0, 0,  0,        8, 9,  1, 0, 0, 0, 0, 0,        0, 0);
    vecs[13] = mk(1, 1, 32'h11,   1, 9, 0, 0,  0,        8, 9,  1, 1, 0, 1, 1, 32'h11,   0, 0);
    vecs[14] = mk(1, 1, 32'h11,   0, 0, 1, 8,  32'h800,  8, 9,  1, 1, 1, 1, 1, 32'h11,   0, 0);
    vecs[15] = mk(1, 1, 32'h11,   0, 0, 1, 9,  32'h900,  8, 9,  1, 1, 1, 1, 1, 32'h11,   0, 0);
    vecs[16] = mk(1, 1, 32'h11,   0, 0, 0, 0,  0,        8, 9,  0, 1, 1, 1, 1, 32'h11,   0, 0);
    vecs[17] = mk(0, 0, 0,        0, 0, 0, 0,  0,        8, 9,  0, 1, 1, 1, 8, 32'h800,  0, 0);
    vecs[18] = mk(0, 0, 0,        0, 0, 0, 0,  0,        8, 9,  1, 0, 1, 1, 9, 32'h900,  0, 0);
    vecs[19] = mk(0, 0, 0,        0, 0, 0, 0,  0,        8, 9,  1, 0, 0, 0, 0, 0,        0, 0);
    // r0 issue is ignored; double issue of r4 raises sticky err.
    vecs[20] = mk(0, 0, 0,        1, 0, 0, 0,  0,        0, 0,  1, 0, 0, 0, 0, 0,        0, 0);
    vecs[21] = mk(0, 0, 0,        1, 4, 0, 0,  0,        4, 0,  1, 0, 0, 0, 0, 0,        0, 0);
    vecs[22] = mk(0, 0, 0,        1, 4, 0, 0,  0,        4, 0,  1, 1, 0, 0, 0, 0,        0, 0);
    vecs[23] = mk(0, 0, 0,        0, 0, 0, 0,  0,        4, 0,  1, 1, 0, 0, 0, 0,        0, 1);
    vecs[24] = mk(0, 0, 0,        0, 0, 0, 0,  0,        4, 0,  1, 1, 0, 0, 0, 0,        0, 1);

    // Outputs must be forced low while in reset, even with wb_we asserted.
    idle_inputs();
    rst = 1'b0;
    wb_we = 1; wb_waddr = 3; wb_wdata = 32'h77;
    #2;
    chk_all_zero("in_reset");
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    cyc();

    for (int i = 0; i < NumVec; i++) begin
      wb_we = vecs[i].wb_we; wb_waddr = vecs[i].wb_waddr; wb_wdata = vecs[i].wb_wdata;
      iss_valid = vecs[i].iss_valid; iss_waddr = vecs[i].iss_waddr;
      lu_valid = vecs[i].lu_valid; lu_waddr = vecs[i].lu_waddr; lu_wdata = vecs[i].lu_wdata;
      raddr1 = vecs[i].raddr1; raddr2 = vecs[i].raddr2;
      @(negedge clk);
      chk($sformatf("v%0d lu_ready", i), 32'(lu_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d rd_busy1", i), 32'(rd_busy1), 32'(vecs[i].e_busy1));
      chk($sformatf("v%0d rd_busy2", i), 32'(rd_busy2), 32'(vecs[i].e_busy2));
      chk($sformatf("v%0d we", i), 32'(we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d waddr", i), 32'(waddr), 32'(vecs[i].e_waddr));
      chk($sformatf("v%0d wdata", i), wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d stallreq", i), 32'(stallreq), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].e_err));
      cyc();
    end

    // Async reset with two buffered results and busy[8] set.
    idle_inputs();
    wb_we = 1; wb_waddr = 1; wb_wdata = 32'h11;
    iss_valid = 1; iss_waddr = 8; cyc();
    iss_waddr = 9; cyc();
    iss_valid = 0; lu_valid = 1; lu_waddr = 8; lu_wdata = 32'h800; cyc();
    lu_waddr = 9; lu_wdata = 32'h900; cyc();
    lu_valid = 0; raddr1 = 8; raddr2 = 9;
    @(negedge clk);
    chk("pre_rst lu_ready", 32'(lu_ready), 0);
    chk("pre_rst rd_busy1", 32'(rd_busy1), 1);
    chk("pre_rst err", 32'(err), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #2;
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d we", k), 32'(we), 0);
      chk($sformatf("post_rst%0d lu_ready", k), 32'(lu_ready), 1);
      chk($sformatf("post_rst%0d rd_busy1", k), 32'(rd_busy1), 0);
      chk($sformatf("post_rst%0d rd_busy2", k), 32'(rd_busy2), 0);
      chk($sformatf("post_rst%0d err", k), 32'(err), 0);
      cyc();
    end

    // Starvation: one entry held back by continuous wb writes.
    idle_inputs();
    iss_valid = 1; iss_waddr = 6; cyc();
    iss_valid = 0; wb_we = 1; wb_waddr = 2; wb_wdata = 32'h22;
    lu_valid = 1; lu_waddr = 6; lu_wdata = 32'h66; cyc();
    lu_valid = 0;
    rise = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (stallreq) begin
        rise = k;
        break;
      end
      cyc();
    end
    chk("stall_rise_cycle", 32'(rise), 6);
    cyc();
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    @(negedge clk);
    chk("drain we", 32'(we), 1);
    chk("drain waddr", 32'(waddr), 6);
    chk("drain wdata", wdata, 32'h66);
    chk("drain stallreq", 32'(stallreq), 1);
    cyc();
    @(negedge clk);
    chk("after_drain stallreq", 32'(stallreq), 0);
    chk("after_drain we", 32'(we), 0);
    chk("after_drain err", 32'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the single regfile write port between two sources: the in-order MEM/WB writeback and a long-latency unit (LU, e.g. a divider or multi-cycle load).
- Buffers LU results in a small FIFO and drains them into cycles where MEM/WB does not write.
- Keeps a per-register busy scoreboard so ID can stall on RAW hazards against outstanding LU results.
- Raises a stall request when buffered LU results have waited too long.
- Sits between MEM/WB, the LU and regfile's we/waddr/wdata inputs.

Parameters:
- DEPTH, 2, LU result FIFO entries (power of two, at least 2).
- MAX_WAIT, 4, cycles the FIFO head may wait before stallreq asserts (at least 1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- wb_we  in  1  MEM/WB write enable
- wb_waddr  in  5  MEM/WB destination register
- wb_wdata  in  32  MEM/WB write data
- iss_valid  in  1  ID issues an LU op this cycle
- iss_waddr  in  5  destination register of the issued LU op
- lu_valid  in  1  LU result valid
- lu_waddr  in  5  LU result destination register
- lu_wdata  in  32  LU result data
- lu_ready  out  1  FIFO can accept an LU result
- raddr1  in  5  ID read address 1, for busy lookup
- raddr2  in  5  ID read address 2, for busy lookup
- rd_busy1  out  1  raddr1 has an outstanding LU write
- rd_busy2  out  1  raddr2 has an outstanding LU write
- we  out  1  regfile write enable
- waddr  out  5  regfile write address
- wdata  out  32  regfile write data
- stallreq  out  1  request MEM/WB bubble to drain the FIFO
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied, busy[31:0]=0, wait_cnt=0, stallreq=0, err=0.
  - All outputs forced to 0 while rst=0, including lu_ready.
  - Reset mid-transfer discards buffered results and all busy bits.
- Write-port arbitration (combinational, same cycle):
  - MEM/WB owns the port when wb_we=1 and wb_waddr!=0: we=1, waddr=wb_waddr, wdata=wb_wdata.
  - Otherwise, if the FIFO is non-empty, the head drains: we=1, waddr/wdata = head; pop at the next clk edge.
  - Otherwise we=0, waddr=0, wdata=0.
  - MEM/WB is never delayed; the LU is the only source that waits.
- FIFO:
  - lu_ready = !full; a push occurs when lu_valid && lu_ready.
  - Push and pop in the same cycle are allowed.
  - Push while full is dropped and sets err.
  - Results never bypass the FIFO; minimum LU-result-to-regfile latency is 1 cycle.
  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- Scoreboard:
  - iss_valid with iss_waddr!=0 sets busy[iss_waddr].
  - A drain write of address A clears busy[A].
  - Set and clear of the same address in one cycle leaves the bit set.
  - iss_valid to an already-busy register sets err; ID must stall instead.
  - An LU push whose lu_waddr is not busy sets err; the result is still buffered.
  - rd_busyN = busy[raddrN] && raddrN!=0, combinational.
  - busy[0] is never set.
- Starvation:
  - wait_cnt increments each cycle the FIFO is non-empty and no drain occurs, saturating at MAX_WAIT.
  - wait_cnt clears on any drain or when the FIFO is empty.
  - stallreq is registered: high on the cycle after wait_cnt reaches MAX_WAIT, held until the first drain cycle, low the cycle after.
- err: sticky until reset.

Decomposition:
- Shared defines file already holds RegAddrBus, RegBus, WriteEnable and ZeroWord; use them.
- Add the new defines there: LuFifoDepth and LuMaxWait defaults.
- One sub-module, rf_wr_fifo: parameterized DEPTH, 5+32-bit entries, push/pop/full/empty/head.
- Scoreboard, arbitration and starvation counter stay in the top module.

Test Plan:
- Reset release, idle: all outputs 0 except lu_ready=1; an LU result r7=0x1234 with wb_we=0 → we=1, waddr=7, wdata=0x1234 exactly one cycle later; busy[7] clears.
- Conflict: issue r5; LU result r5=0xAA while wb writes r3=0x55 every cycle for 3 cycles → regfile sees only r3 writes; r5 written on the first wb_we=0 cycle; rd_busy1 (raddr1=5) stays 1 until then.
- Starvation (MAX_WAIT=4): FIFO holds one entry, wb_we=1 continuously → stallreq rises 5 cycles after the push; wb_we drops → drain, stallreq=0 the following cycle.
- Full: two LU pushes r8, r9 under continuous wb writes → lu_ready=0; a third lu_valid is held off; after 2 free cycles both drain in order r8 then r9; err=0.
- Hazard flags: iss_valid r0 → busy unchanged, rd_busy for raddr=0 is 0; issue r4 twice without a result → err=1 and stays 1.
- Async reset with 2 entries buffered and busy[8]=1 → outputs 0 immediately; after release FIFO empty, rd_busy=0, no stale write.
